// File: rtl/game_judge.sv
// rtl/game_judge.sv - N x N tic-tac-toe judge: board, move handshake, line check, undo stack
module game_judge #(
   parameter int N = 3,
   localparam int CELLS = N * N,
   localparam int IDX_W = $clog2(CELLS),
   localparam int CNT_W = $clog2(CELLS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 move_valid,
   input  logic [IDX_W-1:0]     move_idx,
   output logic                 move_ready,
   input  logic                 undo,
   output logic [2*CELLS-1:0]   board,
   output logic                 turn,
   output logic [1:0]           state,
   output logic                 game_over,
   output logic [1:0]           winner,
   output logic [CELLS-1:0]     win_mask,
   output logic [CNT_W-1:0]     move_count,
   output logic                 err
);

   typedef enum logic [1:0] {
      ST_PLAY  = 2'b00,
      ST_CHECK = 2'b01,
      ST_WIN   = 2'b10,
      ST_DRAW  = 2'b11
   } state_t;

   localparam logic [IDX_W:0]   CELLS_X   = (IDX_W + 1)'(CELLS);
   localparam logic [CNT_W-1:0] CELLS_CNT = CNT_W'(CELLS);

   state_t               state_q, state_d;
   logic [2*CELLS-1:0]   board_q, board_d;
   logic                 turn_q, turn_d;
   logic [1:0]           winner_q, winner_d;
   logic [CELLS-1:0]     win_mask_q, win_mask_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 err_q, err_d;
   logic                 game_over_q, game_over_d;

   // Move history; the move counter doubles as the stack pointer.
   logic [IDX_W-1:0]     stack_q [CELLS];

   logic                 ready_c;
   logic                 move_fire;
   logic                 move_ok;
   logic                 move_bad;
   logic                 undo_ok;
   logic                 undo_bad;
   logic                 idx_in_range;
   logic                 cell_empty;
   logic [IDX_W-1:0]     push_ptr;
   logic [IDX_W-1:0]     top_ptr;
   logic [IDX_W-1:0]     top_idx;
   logic                 line_any;
   logic [CELLS-1:0]     line_mask;

   // True when the N cells starting at 'start' with stride 'step' hold the same non-empty code.
   function automatic logic line_full(input logic [2*CELLS-1:0] b, input int start, input int step);
      logic [1:0] first;
      logic       ok;
      first = b[2*start +: 2];
      ok    = (first != 2'b00);
      for (int k = 1; k < N; k++) begin
         if (b[2*(start + k*step) +: 2] != first) ok = 1'b0;
      end
      return ok;
   endfunction

   // Cell mask of the line starting at 'start' with stride 'step'.
   function automatic logic [CELLS-1:0] line_cells(input int start, input int step);
      logic [CELLS-1:0] m;
      m = '0;
      for (int k = 0; k < N; k++) begin
         m[start + k*step] = 1'b1;
      end
      return m;
   endfunction

   // Evaluate all rows, columns and both diagonals against the registered board.
   always_comb begin
      line_any  = 1'b0;
      line_mask = '0;
      for (int r = 0; r < N; r++) begin
         if (line_full(board_q, r*N, 1)) begin
            line_any  = 1'b1;
            line_mask = line_mask | line_cells(r*N, 1);
         end
      end
      for (int c = 0; c < N; c++) begin
         if (line_full(board_q, c, N)) begin
            line_any  = 1'b1;
            line_mask = line_mask | line_cells(c, N);
         end
      end
      if (line_full(board_q, 0, N + 1)) begin
         line_any  = 1'b1;
         line_mask = line_mask | line_cells(0, N + 1);
      end
      if (line_full(board_q, N - 1, N - 1)) begin
         line_any  = 1'b1;
         line_mask = line_mask | line_cells(N - 1, N - 1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_PLAY;
      else       state_q <= state_d;
   end

   // FSM next state: undo always returns to PLAY, CHECK resolves in one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PLAY: begin
            if (move_ok) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (line_any)                   state_d = ST_WIN;
            else if (count_q == CELLS_CNT)  state_d = ST_DRAW;
            else                            state_d = ST_PLAY;
         end
         ST_WIN, ST_DRAW: begin
            if (undo_ok) state_d = ST_PLAY;
         end
         default: state_d = ST_PLAY;
      endcase
   end

   // FSM outputs: handshake and request classification.
   always_comb begin
      ready_c      = (state_q == ST_PLAY) && !undo;
      move_fire    = move_valid && ready_c;
      idx_in_range = ({1'b0, move_idx} < CELLS_X);
      cell_empty   = (board_q[{move_idx, 1'b0} +: 2] == 2'b00);
      move_ok      = move_fire && idx_in_range && cell_empty;
      move_bad     = move_fire && !(idx_in_range && cell_empty);
      undo_ok      = undo && (state_q != ST_CHECK) && (count_q != '0);
      undo_bad     = undo && !undo_ok;
   end

   assign push_ptr = IDX_W'(count_q);
   assign top_ptr  = IDX_W'(count_q - 1'b1);
   assign top_idx  = stack_q[top_ptr];

   // Datapath next state: board, turn, counter, result registers.
   always_comb begin
      board_d     = board_q;
      turn_d      = turn_q;
      count_d     = count_q;
      winner_d    = winner_q;
      win_mask_d  = win_mask_q;
      err_d       = move_bad || undo_bad;
      game_over_d = (state_d == ST_WIN) || (state_d == ST_DRAW);
      if (undo_ok) begin
         board_d[{top_idx, 1'b0} +: 2] = 2'b00;
         turn_d     = ~turn_q;
         count_d    = count_q - 1'b1;
         winner_d   = 2'b00;
         win_mask_d = '0;
      end else if (move_ok) begin
         board_d[{move_idx, 1'b0} +: 2] = turn_q ? 2'b10 : 2'b01;
         turn_d  = ~turn_q;
         count_d = count_q + 1'b1;
      end else if ((state_q == ST_CHECK) && line_any) begin
         // turn has already toggled, so the last mover is the opposite of turn_q.
         winner_d   = turn_q ? 2'b01 : 2'b10;
         win_mask_d = line_mask;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         board_q     <= '0;
         turn_q      <= 1'b0;
         count_q     <= '0;
         winner_q    <= 2'b00;
         win_mask_q  <= '0;
         err_q       <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         board_q     <= board_d;
         turn_q      <= turn_d;
         count_q     <= count_d;
         winner_q    <= winner_d;
         win_mask_q  <= win_mask_d;
         err_q       <= err_d;
         game_over_q <= game_over_d;
      end
   end

   // History push; entries above the pointer are dead, so no reset is needed.
   always_ff @(posedge clk) begin
      if (!reset && move_ok) stack_q[push_ptr] <= move_idx;
   end

   assign move_ready = ready_c;
   assign board      = board_q;
   assign turn       = turn_q;
   assign state      = state_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;
   assign win_mask   = win_mask_q;
   assign move_count = count_q;
   assign err        = err_q;

endmodule

// File: tb/tb_game_judge.sv
// tb/tb_game_judge.sv - directed self-checking bench for game_judge (N=3 and N=4)
module tb_game_judge;

   logic        clk;
   int          checks;
   int          errors;

   logic        a_reset, a_move_valid, a_undo;
   logic [3:0]  a_move_idx;
   logic        a_move_ready, a_turn, a_game_over, a_err;
   logic [17:0] a_board;
   logic [1:0]  a_state, a_winner;
   logic [8:0]  a_win_mask;
   logic [3:0]  a_move_count;

   logic        b_reset, b_move_valid, b_undo;
   logic [3:0]  b_move_idx;
   logic        b_move_ready, b_turn, b_game_over, b_err;
   logic [31:0] b_board;
   logic [1:0]  b_state, b_winner;
   logic [15:0] b_win_mask;
   logic [4:0]  b_move_count;

   game_judge #(.N(3)) dut_a (
      .clk(clk), .reset(a_reset), .move_valid(a_move_valid), .move_idx(a_move_idx),
      .move_ready(a_move_ready), .undo(a_undo), .board(a_board), .turn(a_turn),
      .state(a_state), .game_over(a_game_over), .winner(a_winner), .win_mask(a_win_mask),
      .move_count(a_move_count), .err(a_err)
   );

   game_judge #(.N(4)) dut_b (
      .clk(clk), .reset(b_reset), .move_valid(b_move_valid), .move_idx(b_move_idx),
      .move_ready(b_move_ready), .undo(b_undo), .board(b_board), .turn(b_turn),
      .state(b_state), .game_over(b_game_over), .winner(b_winner), .win_mask(b_win_mask),
      .move_count(b_move_count), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
   endtask

   task automatic move_a(input logic [3:0] idx);
      int waited;
      waited = 0;
      while (!a_move_ready && waited < 4) begin
         tick();
         waited++;
      end
      checks++;
      if (a_move_ready !== 1'b1) begin
         errors++;
         $display("FAIL move_a_ready_timeout idx=%0d got=%b want=1", idx, a_move_ready);
      end
      a_move_valid = 1'b1;
      a_move_idx   = idx;
      tick();
      a_move_valid = 1'b0;
      tick();
   endtask

   task automatic undo_a();
      a_undo = 1'b1;
      tick();
      a_undo = 1'b0;
   endtask

   task automatic move_b(input logic [3:0] idx);
      int waited;
      waited = 0;
      while (!b_move_ready && waited < 4) begin
         tick();
         waited++;
      end
      checks++;
      if (b_move_ready !== 1'b1) begin
         errors++;
         $display("FAIL move_b_ready_timeout idx=%0d got=%b want=1", idx, b_move_ready);
      end
      b_move_valid = 1'b1;
      b_move_idx   = idx;
      tick();
      b_move_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset_a();
      checks++;
      if ({a_board, a_turn, a_state, a_game_over, a_winner, a_win_mask, a_move_count, a_err, a_move_ready}
          !== {18'h0, 1'b0, 2'b00, 1'b0, 2'b00, 9'h0, 4'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_values board=%h turn=%b state=%b go=%b win=%b mask=%h cnt=%0d err=%b rdy=%b want all zero rdy=1",
                  a_board, a_turn, a_state, a_game_over, a_winner, a_win_mask, a_move_count, a_err, a_move_ready);
      end
   endtask

   task automatic test_row_win_and_undo();
      reset_a();
      move_a(4'd0); move_a(4'd3); move_a(4'd1); move_a(4'd4); move_a(4'd2);
      checks++;
      if ({a_state, a_winner, a_win_mask, a_game_over, a_move_ready} !== {2'b10, 2'b01, 9'b000000111, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL row_win state=%b winner=%b mask=%b go=%b rdy=%b want 10 01 000000111 1 0",
                  a_state, a_winner, a_win_mask, a_game_over, a_move_ready);
      end
      checks++;
      if (a_board !== 18'h00295) begin
         errors++;
         $display("FAIL row_win_board got=%h want=00295", a_board);
      end
      undo_a();
      checks++;
      if ({a_board, a_turn, a_move_count, a_state, a_win_mask, a_winner, a_game_over}
          !== {18'h00285, 1'b0, 4'd4, 2'b00, 9'h0, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL undo_from_win board=%h turn=%b cnt=%0d state=%b mask=%b winner=%b go=%b want 00285 0 4 00 0 00 0",
                  a_board, a_turn, a_move_count, a_state, a_win_mask, a_winner, a_game_over);
      end
      undo_a();
      checks++;
      if ({a_board, a_turn, a_move_count} !== {18'h00085, 1'b1, 4'd3}) begin
         errors++;
         $display("FAIL second_undo board=%h turn=%b cnt=%0d want 00085 1 3", a_board, a_turn, a_move_count);
      end
   endtask

   task automatic test_draw();
      reset_a();
      move_a(4'd0); move_a(4'd1); move_a(4'd2); move_a(4'd4); move_a(4'd3);
      move_a(4'd5); move_a(4'd7); move_a(4'd6); move_a(4'd8);
      checks++;
      if ({a_state, a_winner, a_win_mask, a_move_count, a_game_over} !== {2'b11, 2'b00, 9'h0, 4'd9, 1'b1}) begin
         errors++;
         $display("FAIL draw state=%b winner=%b mask=%b cnt=%0d go=%b want 11 00 0 9 1",
                  a_state, a_winner, a_win_mask, a_move_count, a_game_over);
      end
      a_move_valid = 1'b1;
      a_move_idx   = 4'd0;
      tick();
      a_move_valid = 1'b0;
      tick();
      checks++;
      if ({a_err, a_state, a_move_count} !== {1'b0, 2'b11, 4'd9}) begin
         errors++;
         $display("FAIL draw_blocks_move err=%b state=%b cnt=%0d want 0 11 9", a_err, a_state, a_move_count);
      end
   endtask

   task automatic test_double_line();
      reset_a();
      move_a(4'd0); move_a(4'd1); move_a(4'd2); move_a(4'd3); move_a(4'd6);
      move_a(4'd5); move_a(4'd8); move_a(4'd7); move_a(4'd4);
      checks++;
      if ({a_state, a_winner, a_win_mask, a_move_count} !== {2'b10, 2'b01, 9'b101010101, 4'd9}) begin
         errors++;
         $display("FAIL double_line state=%b winner=%b mask=%b cnt=%0d want 10 01 101010101 9",
                  a_state, a_winner, a_win_mask, a_move_count);
      end
   endtask

   task automatic test_rejections();
      reset_a();
      move_a(4'd0);
      a_move_valid = 1'b1;
      a_move_idx   = 4'd0;
      tick();
      a_move_valid = 1'b0;
      checks++;
      if ({a_err, a_board, a_turn, a_state, a_move_count} !== {1'b1, 18'h00001, 1'b1, 2'b00, 4'd1}) begin
         errors++;
         $display("FAIL occupied_reject err=%b board=%h turn=%b state=%b cnt=%0d want 1 00001 1 00 1",
                  a_err, a_board, a_turn, a_state, a_move_count);
      end
      tick();
      checks++;
      if (a_err !== 1'b0) begin
         errors++;
         $display("FAIL err_one_cycle got=%b want=0", a_err);
      end
      a_move_valid = 1'b1;
      a_move_idx   = 4'd9;
      tick();
      a_move_valid = 1'b0;
      checks++;
      if ({a_err, a_state, a_board, a_move_count} !== {1'b1, 2'b00, 18'h00001, 4'd1}) begin
         errors++;
         $display("FAIL index_range_reject err=%b state=%b board=%h cnt=%0d want 1 00 00001 1",
                  a_err, a_state, a_board, a_move_count);
      end

      reset_a();
      undo_a();
      checks++;
      if ({a_err, a_move_count, a_state} !== {1'b1, 4'd0, 2'b00}) begin
         errors++;
         $display("FAIL undo_empty err=%b cnt=%0d state=%b want 1 0 00", a_err, a_move_count, a_state);
      end

      a_move_valid = 1'b1;
      a_move_idx   = 4'd4;
      tick();
      a_move_valid = 1'b0;
      checks++;
      if (a_state !== 2'b01) begin
         errors++;
         $display("FAIL enter_check state=%b want=01", a_state);
      end
      a_undo = 1'b1;
      tick();
      a_undo = 1'b0;
      checks++;
      if ({a_err, a_move_count, a_board, a_state} !== {1'b1, 4'd1, 18'h00100, 2'b00}) begin
         errors++;
         $display("FAIL undo_in_check err=%b cnt=%0d board=%h state=%b want 1 1 00100 00",
                  a_err, a_move_count, a_board, a_state);
      end

      a_move_valid = 1'b1;
      a_move_idx   = 4'd0;
      a_undo       = 1'b1;
      #1;
      checks++;
      if (a_move_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_with_undo got=%b want=0", a_move_ready);
      end
      tick();
      a_move_valid = 1'b0;
      a_undo       = 1'b0;
      checks++;
      if ({a_board, a_move_count, a_turn, a_state, a_err} !== {18'h0, 4'd0, 1'b0, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL move_and_undo board=%h cnt=%0d turn=%b state=%b err=%b want 0 0 0 00 0",
                  a_board, a_move_count, a_turn, a_state, a_err);
      end
   endtask

   task automatic test_n4_and_reset_in_check();
      b_reset = 1'b1;
      tick();
      b_reset = 1'b0;
      move_b(4'd0); move_b(4'd1); move_b(4'd4); move_b(4'd2);
      move_b(4'd8); move_b(4'd3); move_b(4'd12);
      checks++;
      if ({b_state, b_winner, b_win_mask, b_board} !== {2'b10, 2'b01, 16'h1111, 32'h010101A9}) begin
         errors++;
         $display("FAIL n4_column_win state=%b winner=%b mask=%h board=%h want 10 01 1111 010101a9",
                  b_state, b_winner, b_win_mask, b_board);
      end
      b_undo = 1'b1;
      tick();
      b_undo = 1'b0;
      checks++;
      if ({b_state, b_turn, b_move_count} !== {2'b00, 1'b0, 5'd6}) begin
         errors++;
         $display("FAIL n4_undo state=%b turn=%b cnt=%0d want 00 0 6", b_state, b_turn, b_move_count);
      end
      b_move_valid = 1'b1;
      b_move_idx   = 4'd13;
      tick();
      b_move_valid = 1'b0;
      checks++;
      if (b_state !== 2'b01) begin
         errors++;
         $display("FAIL n4_check state=%b want=01", b_state);
      end
      b_reset = 1'b1;
      tick();
      b_reset = 1'b0;
      checks++;
      if ({b_board, b_turn, b_state, b_game_over, b_winner, b_win_mask, b_move_count, b_err}
          !== {32'h0, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL n4_reset_in_check board=%h turn=%b state=%b go=%b win=%b mask=%h cnt=%0d err=%b want all zero",
                  b_board, b_turn, b_state, b_game_over, b_winner, b_win_mask, b_move_count, b_err);
      end
      b_undo = 1'b1;
      tick();
      b_undo = 1'b0;
      checks++;
      if ({b_err, b_move_count} !== {1'b1, 5'd0}) begin
         errors++;
         $display("FAIL n4_stack_discarded err=%b cnt=%0d want 1 0", b_err, b_move_count);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      a_reset      = 1'b1;
      a_move_valid = 1'b0;
      a_move_idx   = 4'd0;
      a_undo       = 1'b0;
      b_reset      = 1'b1;
      b_move_valid = 1'b0;
      b_move_idx   = 4'd0;
      b_undo       = 1'b0;
      tick();
      tick();
      a_reset = 1'b0;
      b_reset = 1'b0;
      test_reset();
      test_row_win_and_undo();
      test_draw();
      test_double_line();
      test_rejections();
      test_n4_and_reset_in_check();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
